fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch initiator for the RV32 core. Drives the word address into the synchronous, one-cycle-latency instruction memory and captures each returned word with its PC. Delivers instruction/PC pairs to decode over a valid/ready handshake, with a 2-entry skid buffer so backpressure never drops or duplicates an instruction. Accepts branch/jump redirects from execute and discards all wrong-path words.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `imem_pc_o` out 32: byte address to instruction memory. Memory samples it every cycle; the word for the address presented in cycle N appears on `imem_instr_i` in cycle N+1.
- `imem_instr_i` in 32: registered instruction word from memory.
- `instr_o` out 32: instruction at the head of the buffer.
- `pc_o` out 32: PC of `instr_o`.
- `valid_o` out 1: head entry valid.
- `ready_i` in 1: decode accepts; a transfer (pop) occurs when `valid_o & ready_i` at a rising edge.
- `redirect_i` in 1: redirect request from execute.
- `redirect_pc_i` in 32: redirect target; bits [1:0] ignored and treated as 00.

## Operation
- State: `fetch_pc`, `inflight_v` (a request issued last cycle whose response arrives this cycle is wanted), `inflight_pc`, and a 2-entry FIFO of {pc, instr} with `count` 0..2.
- `imem_pc_o = fetch_pc` (registered, no combinational path from inputs).
- Issue rule: `issue = (count + inflight_v - pop) <= 1`. When issuing: `inflight_v <= 1`, `inflight_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4`. Otherwise `inflight_v <= 0` and `fetch_pc` holds. The memory re-reads a held address; that response is ignored.
- Response: if `inflight_v`, push {`inflight_pc`, `imem_instr_i`} into the FIFO. The credit rule guarantees space, so overflow is impossible and is flagged by an assertion.
- Outputs: `valid_o = (count != 0)`. `instr_o` and `pc_o` come from the FIFO head. No bypass path from memory to decode.
- Redirect takes priority over issue and push:
  - `fetch_pc <= {redirect_pc_i[31:2], 2'b00}`, `count <= 0`, `inflight_v <= 0`.
  - A handshake in the redirect cycle still counts as a completed transfer.
  - The response arriving in the redirect cycle and the address presented in it are both discarded.
- Arithmetic: the PC increment is modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Simultaneous push and pop: head advances, new entry is written behind it, and `count` is unchanged.
- Reset (asynchronous, any time, including mid-stream):
  - `fetch_pc = RESET_PC`, `inflight_v = 0`, `count = 0`, FIFO contents = 0.
  - Hence `imem_pc_o = RESET_PC`, `valid_o = 0`, `instr_o = 0`, `pc_o = 0` while `rst_n` is low.

## Timing
- C0 is the first cycle with `rst_n` high. `imem_pc_o = RESET_PC` in C0, `RESET_PC+4` in C1, `RESET_PC+8` in C2.
- First `valid_o` occurs in C2 with `pc_o = RESET_PC`. Fetch-to-decode latency is 2 cycles.
- Steady state with `ready_i = 1`: one instruction per cycle (`count = 1`, `inflight_v = 1`).
- Redirect in cycle R:
  - `valid_o = 0` in R+1 and R+2.
  - `imem_pc_o` = target in R+1.
  - First `valid_o` in R+3 with `pc_o` = target.
- Under backpressure: at most 2 buffered entries plus 0 in flight. On release, `valid_o` stays continuous and fetch resumes without a bubble beyond the credit rule.

## Structure
- Shared package `riscv_pkg`: `XLEN = 32`, `INSTR_NOP = 32'h0000_0013`, default `RESET_PC`, and a `fetch_entry` struct {pc, instr}.
- Sub-module `fetch_skid_buf`: 2-entry FIFO with push/pop/flush, `count`, and head outputs. It has no knowledge of PCs or redirects.
- The top level holds the PC register, the in-flight tracking, and the issue/redirect logic.

## Test plan
- Reset release with `RESET_PC = 0`, memory words [0]=07b00093, [1]=00510113, [2]=002081b3, `ready_i = 1`:
  - `imem_pc_o` = 0, 4, 8 in C0–C2.
  - `valid_o` from C2 with (pc, instr) = (0, 07b00093), (4, 00510113), (8, 002081b3) on consecutive cycles.
- `ready_i = 0` from reset:
  - `count` reaches 2 holding pc 0 and 4, and `imem_pc_o` holds 8.
  - After raising `ready_i`, the sequence continues 0, 4, 8, 12 with no gap, loss, or duplicate.
- Redirect to 32'h40 in cycle R during streaming:
  - `valid_o` is low in R+1 and R+2.
  - `pc_o` = 32'h40 in R+3.
  - No old-path PC appears after R.
- `redirect_pc_i` = 32'h43: fetch starts at 32'h40 and `pc_o` = 32'h40.
- Redirect to 32'hFFFF_FFFC with `ready_i = 1`: `pc_o` sequence is FFFF_FFFC, then 0000_0000, then 0000_0004.
- Assert `rst_n` low mid-cycle while `count = 2`:
  - `valid_o`, `pc_o`, and `instr_o` go to 0 immediately and `imem_pc_o = RESET_PC`.
  - After release, C0–C2 match the first scenario.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the fetch path.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO with flush; payload is opaque to this block.
module fetch_skid_buf #(
    parameter int unsigned Width = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [1:0]       o_count,
    output logic [Width-1:0] o_head
);

    logic [Width-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            // With count == 2 and a pop, the write slot is the head being popped.
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_pop && !i_flush && r_count == 2'd2));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_pop && !i_flush && r_count == 2'd0));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, one-cycle memory tracking, redirect flush, skid buffer.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_pc_o,
    input  logic [XLEN-1:0] imem_instr_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o,
    input  logic            ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i
);

    logic [XLEN-1:0] r_fetch_pc;
    logic            r_inflight_v;
    logic [XLEN-1:0] r_inflight_pc;

    logic [1:0]      w_count;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [2:0]      w_occupancy;
    logic [XLEN-1:0] w_redirect_tgt;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    assign w_pop          = valid_o & ready_i;
    assign w_push         = r_inflight_v & ~redirect_i;
    assign w_redirect_tgt = redirect_pc_i & ~32'd3;
    assign w_push_entry   = '{pc: r_inflight_pc, instr: imem_instr_i};

    // Credit check: entries held after this edge plus the new request must fit in 2.
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight_v} - {2'b00, w_pop};
    assign w_issue     = (w_occupancy <= 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_v  <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_i) begin
            r_fetch_pc   <= w_redirect_tgt;
            r_inflight_v <= 1'b0;
        end else if (w_issue) begin
            r_fetch_pc    <= r_fetch_pc + 32'd4;
            r_inflight_v  <= 1'b1;
            r_inflight_pc <= r_fetch_pc;
        end else begin
            r_inflight_v <= 1'b0;
        end
    end

    fetch_skid_buf #(
        .Width($bits(fetch_entry_t))
    ) u_skid_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign imem_pc_o = r_fetch_pc;
    assign valid_o   = (w_count != 2'd0);
    assign instr_o   = w_head.instr;
    assign pc_o      = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_pc_o;
    logic [31:0] imem_instr_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_pc_o     (imem_pc_o),
        .imem_instr_i  (imem_instr_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h07b0_0093;
            32'h4:   return 32'h0051_0113;
            32'h8:   return 32'h0020_81b3;
            default: return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    always @(posedge clk) imem_instr_i <= mem_word(imem_pc_o);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into C0.
    task automatic release_reset();
        rst_n      = 1'b0;
        redirect_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (imem_pc_o !== 32'h0) begin
            errors++; $display("FAIL reset_imem_pc: got %h want %h", imem_pc_o, 32'h0);
        end
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", valid_o);
        end
        checks++;
        if (pc_o !== 32'h0) begin
            errors++; $display("FAIL reset_pc: got %h want 0", pc_o);
        end
        checks++;
        if (instr_o !== 32'h0) begin
            errors++; $display("FAIL reset_instr: got %h want 0", instr_o);
        end
    endtask

    // Expects to be entered in C0 with ready_i = 1; walks C0..C4.
    task automatic test_startup(input string tag);
        logic [31:0] exp_pc;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            checks++;
            if (imem_pc_o !== 32'(i * 4)) begin
                errors++;
                $display("FAIL %s_imem_c%0d: got %h want %h", tag, i, imem_pc_o, 32'(i * 4));
            end
            checks++;
            if (valid_o !== (i >= 2)) begin
                errors++;
                $display("FAIL %s_valid_c%0d: got %b want %b", tag, i, valid_o, (i >= 2));
            end
            if (i >= 2) begin
                exp_pc = 32'((i - 2) * 4);
                checks++;
                if (pc_o !== exp_pc || instr_o !== mem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL %s_entry_c%0d: got %h/%h want %h/%h", tag, i, pc_o, instr_o,
                             exp_pc, mem_word(exp_pc));
                end
            end
        end
    endtask

    task automatic test_stream();
        ready_i = 1'b1;
        release_reset();
        test_startup("stream");
    endtask

    task automatic test_redirect();
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        step();
        redirect_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || imem_pc_o !== 32'h40) begin
            errors++;
            $display("FAIL redir_r1: got valid %b imem %h want 0/00000040", valid_o, imem_pc_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL redir_r2_valid: got %b want 0", valid_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h40 || instr_o !== mem_word(32'h40)) begin
            errors++;
            $display("FAIL redir_r3: got %b/%h/%h want 1/00000040/%h", valid_o, pc_o, instr_o,
                     mem_word(32'h40));
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h44) begin
            errors++; $display("FAIL redir_r4: got %b/%h want 1/00000044", valid_o, pc_o);
        end
    endtask

    task automatic test_misaligned();
        redirect_i = 1'b1; redirect_pc_i = 32'h43;
        step();
        redirect_i = 1'b0;
        checks++;
        if (imem_pc_o !== 32'h40) begin
            errors++; $display("FAIL misalign_imem: got %h want 00000040", imem_pc_o);
        end
        step();
        step();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h40) begin
            errors++; $display("FAIL misalign_pc: got %b/%h want 1/00000040", valid_o, pc_o);
        end
    endtask

    task automatic test_wrap();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        checks++;
        if (imem_pc_o !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_imem: got %h want fffffffc", imem_pc_o);
        end
        step();
        step();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC || instr_o !== mem_word(32'hFFFF_FFFC)) begin
            errors++; $display("FAIL wrap_top: got %b/%h/%h want 1/fffffffc/%h", valid_o, pc_o,
                               instr_o, mem_word(32'hFFFF_FFFC));
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'h07b0_0093) begin
            errors++; $display("FAIL wrap_zero: got %b/%h/%h want 1/00000000/07b00093", valid_o,
                               pc_o, instr_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h4) begin
            errors++; $display("FAIL wrap_four: got %b/%h want 1/00000004", valid_o, pc_o);
        end
    endtask

    task automatic test_back_to_back();
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        step();
        redirect_pc_i = 32'h200;
        checks++;
        if (imem_pc_o !== 32'h100 || valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b_first: got %h/%b want 00000100/0", imem_pc_o, valid_o);
        end
        step();
        redirect_i = 1'b0;
        checks++;
        if (imem_pc_o !== 32'h200 || valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got %h/%b want 00000200/0", imem_pc_o, valid_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b_stale: got valid %b pc %h want 0", valid_o, pc_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h200) begin
            errors++; $display("FAIL b2b_target: got %b/%h want 1/00000200", valid_o, pc_o);
        end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        release_reset();
        repeat (4) step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid_o !== 1'b1 || pc_o !== 32'h0 || imem_pc_o !== 32'h8) begin
                errors++; $display("FAIL bp_hold%0d: got %b/%h/%h want 1/00000000/00000008", k,
                                   valid_o, pc_o, imem_pc_o);
            end
            if (k == 0) step();
        end
        ready_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (valid_o !== 1'b1 || pc_o !== 32'(k * 4) || instr_o !== mem_word(32'(k * 4))) begin
                errors++; $display("FAIL bp_release%0d: got %b/%h/%h want 1/%h/%h", k, valid_o,
                                   pc_o, instr_o, 32'(k * 4), mem_word(32'(k * 4)));
            end
        end
    endtask

    task automatic test_reset_midstream();
        ready_i = 1'b0;
        release_reset();
        repeat (4) step();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || pc_o !== 32'h0 || instr_o !== 32'h0 || imem_pc_o !== 32'h0) begin
            errors++; $display("FAIL midreset: got %b/%h/%h/%h want all zero", valid_o, pc_o,
                               instr_o, imem_pc_o);
        end
        ready_i = 1'b1;
        release_reset();
        test_startup("post_reset");
    endtask

    initial begin
        rst_n         = 1'b1;
        ready_i       = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        #1 rst_n = 1'b0;
        #2;
        test_reset();
        test_stream();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
